wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_pkg.sv | 17 +
 rtl/ll_fifo.sv | 53 +++++
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 tb/tb_wb_port_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the write-back port arbiter
package wb_pkg;

  localparam int LL_DEPTH_DEF     = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ll_entry_t;

endpackage

// File: rtl/ll_fifo.sv
// rtl/ll_fifo.sv - depth-parameterised FIFO holding long-latency unit results
module ll_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = LL_DEPTH_DEF,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  ll_entry_t     pushEntry,
  input  logic          pop,
  output ll_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  ll_entry_t      mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic           doPush;
  logic           doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between the
// write-back stage and buffered long-latency results, stalling W on starvation
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int LL_DEPTH     = LL_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [63:0] ResultW,
  input  logic        LLValid,
  input  logic [4:0]  LLRd,
  input  logic [63:0] LLData,
  output logic        LLReady,
  output logic        RegWriteR,
  output logic [4:0]  RdR,
  output logic [63:0] WDataR,
  output logic        StallW
);

  localparam int CW = $clog2(LL_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_state_t      state;
  wb_state_t      nextState;
  logic [SW-1:0]  starveCnt;
  ll_entry_t      llEntry;
  ll_entry_t      fifoHead;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [CW-1:0]  unusedCount;
  logic           fifoPush;
  logic           fifoPop;
  logic           pipeWrite;
  logic           pipeWins;

  assign pipeWrite = RegWriteW && (RdW != 5'd0);
  assign pipeWins  = (state == NORMAL) && pipeWrite;
  assign llEntry   = '{rd: LLRd, data: LLData};
  assign LLReady   = !reset && !fifoFull;
  assign fifoPush  = LLValid && LLReady;

  ll_fifo #(.DEPTH(LL_DEPTH)) uFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifoPush),
    .pushEntry (llEntry),
    .pop       (fifoPop),
    .head      (fifoHead),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .count     (unusedCount)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NORMAL;
    else       state <= nextState;
  end

  // Enter DRAIN on the edge where the starvation count reaches the limit.
  always_comb begin
    nextState = state;
    case (state)
      NORMAL: begin
        if (pipeWins && !fifoEmpty && (starveCnt >= SW'(STARVE_LIMIT - 1)))
          nextState = DRAIN;
      end
      DRAIN:   nextState = NORMAL;
      default: nextState = NORMAL;
    endcase
  end

  always_comb begin
    RegWriteR = 1'b0;
    RdR       = 5'd0;
    WDataR    = 64'd0;
    StallW    = 1'b0;
    fifoPop   = 1'b0;
    if (!reset) begin
      if (state == DRAIN) StallW = 1'b1;
      if (pipeWins) begin
        RegWriteR = 1'b1;
        RdR       = RdW;
        WDataR    = ResultW;
      end else if (!fifoEmpty) begin
        fifoPop = 1'b1;
        if (fifoHead.rd != 5'd0) begin
          RegWriteR = 1'b1;
          RdR       = fifoHead.rd;
          WDataR    = fifoHead.data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (fifoPop || fifoEmpty) begin
      starveCnt <= '0;
    end else if (pipeWins && (starveCnt != SW'(STARVE_LIMIT))) begin
      starveCnt <= starveCnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed bench for wb_port_arbiter
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int LL_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [63:0] ResultW;
  logic        LLValid;
  logic [4:0]  LLRd;
  logic [63:0] LLData;
  logic        LLReady;
  logic        RegWriteR;
  logic [4:0]  RdR;
  logic [63:0] WDataR;
  logic        StallW;

  int testsRun = 0;
  int testsFailed = 0;

  ll_entry_t mq[$];
  int        starve = 0;
  bit        drain = 0;
  bit        lastPushed;

  wb_port_arbiter #(.LL_DEPTH(LL_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .LLValid   (LLValid),
    .LLRd      (LLRd),
    .LLData    (LLData),
    .LLReady   (LLReady),
    .RegWriteR (RegWriteR),
    .RdR       (RdR),
    .WDataR    (WDataR),
    .StallW    (StallW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] res,
                       input logic llv, input logic [4:0] llrd, input logic [63:0] lld);
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    LLValid   = llv;
    LLRd      = llrd;
    LLData    = lld;
  endtask

  // Reference: the port goes to the pipeline unless a stall cycle is owed;
  // otherwise the oldest queued LL result takes it.
  task automatic tick(input string tag);
    logic        expWe, expStall, expReady;
    logic [4:0]  expRd;
    logic [63:0] expData;
    bit          pw, popped, pipeWon, wasEmpty, nextDrain;
    ll_entry_t   h;
    #1;
    expWe = 0; expRd = 0; expData = 0; expStall = 0; expReady = 0;
    popped = 0; pipeWon = 0; lastPushed = 0;
    pw = RegWriteW && (RdW != 0);
    wasEmpty = (mq.size() == 0);
    if (!reset) begin
      expReady = (mq.size() < LL_DEPTH);
      if (drain) begin
        expStall = 1;
        popped = !wasEmpty;
      end else if (pw) begin
        pipeWon = 1; expWe = 1; expRd = RdW; expData = ResultW;
      end else begin
        popped = !wasEmpty;
      end
      if (popped) begin
        h = mq[0];
        if (h.rd != 0) begin
          expWe = 1; expRd = h.rd; expData = h.data;
        end
      end
    end
    check(tag, {RegWriteR, RdR, WDataR, StallW, LLReady},
               {expWe, expRd, expData, expStall, expReady});
    @(posedge clk);
    if (reset) begin
      mq.delete(); starve = 0; drain = 0;
    end else begin
      if (popped) void'(mq.pop_front());
      if (LLValid && expReady) begin
        mq.push_back('{rd: LLRd, data: LLData});
        lastPushed = 1;
      end
      nextDrain = !drain && pipeWon && !wasEmpty && (starve + 1 >= STARVE_LIMIT);
      if (popped || wasEmpty) starve = 0;
      else if (pipeWon)       starve = starve + 1;
      drain = nextDrain;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 5'd3, 64'h55, 1, 5'd2, 64'h77);
    tick("reset_outputs");
    tick("reset_outputs2");
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick("idle_after_reset");

    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd5, 64'hAA, 0, 0, 0);
      tick("pipe_only");
    end

    drive(0, 0, 0, 1, 5'd7, 64'h1234);
    tick("ll_push");
    drive(0, 0, 0, 0, 0, 0);
    tick("ll_write_latency1");
    tick("ll_idle");

    drive(1, 5'd9, 64'h9999, 1, 5'd3, 64'h3333);
    tick("starve_push");
    drive(1, 5'd9, 64'h9999, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick("starve_seq");

    drive(1, 5'd9, 64'h9999, 1, 5'd1, 64'h1111);
    tick("full_push1");
    drive(1, 5'd9, 64'h9999, 1, 5'd2, 64'h2222);
    tick("full_push2");
    drive(1, 5'd9, 64'h9999, 1, 5'd4, 64'h4444);
    for (int i = 0; i < 14; i++) begin
      tick("full_hold");
      if (lastPushed) LLValid = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("full_drain_idle");

    drive(1, 5'd9, 64'h9999, 1, 5'd10, 64'hA0);
    tick("rst_push1");
    drive(1, 5'd9, 64'h9999, 1, 5'd11, 64'hB0);
    tick("rst_push2");
    drive(1, 5'd9, 64'h9999, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("rst_starve");
    #1;
    check("drain_before_reset", {71'd0, StallW}, 72'd1);
    reset = 1'b1;
    tick("reset_mid_drain");
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("no_stale_after_reset");

    drive(0, 0, 0, 1, 5'd6, 64'h6666);
    tick("rd0_push");
    drive(1, 5'd0, 64'hFF, 0, 0, 0);
    tick("pipe_rd0_pops_fifo");
    drive(0, 0, 0, 1, 5'd0, 64'hDEAD);
    tick("ll_rd0_push");
    drive(0, 0, 0, 0, 0, 0);
    tick("ll_rd0_pop_silent");

    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
            {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7) == 0 ? 0 : $urandom), {$urandom, $urandom});
      reset = ($urandom_range(0, 63) == 0);
      tick("random");
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
